map_ctl: RTL

Level-load sequencer and tile-lookup arbiter that sits between `map_rom` and the game logic. On a level change it drives `map_rom` and waits out the ROM's registered read. It then captures the 150-bit wall map into a local register. After that it serves single-tile wall queries from two requesters, player-1 and player-2 collision logic, sharing one lookup slot per cycle under round-robin arbitration.

---
 rtl/map_ctl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/map_ctl.sv
`default_nettype none
// ============================================================================
// Module      : map_ctl
// Description : Level-load sequencer for map_rom plus a two-requester,
//               round-robin tile-lookup arbiter over the captured wall map.
// Revision    : 1.0 - initial release
// ============================================================================
module map_ctl #(
  parameter int COLS   = 15,
  parameter int ROWS   = 10,
  parameter int LEVELS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  input  logic [1:0]             load_level,
  output logic                   load_ready,
  output logic                   load_done,
  output logic                   load_err,
  output logic [1:0]             rom_level,
  input  logic [COLS*ROWS-1:0]   rom_map,
  output logic                   map_valid,
  output logic [1:0]             cur_level,
  input  logic                   q0_valid,
  input  logic [3:0]             q0_x,
  input  logic [3:0]             q0_y,
  output logic                   q0_ready,
  input  logic                   q1_valid,
  input  logic [3:0]             q1_x,
  input  logic [3:0]             q1_y,
  output logic                   q1_ready,
  output logic                   r0_valid,
  output logic                   r0_wall,
  output logic                   r1_valid,
  output logic                   r1_wall
);

  localparam int MAP_W = COLS * ROWS;
  localparam int IDX_W = $clog2(MAP_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT1 = 2'd1,
    S_WAIT2 = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               load_acc;
  logic               level_ok;
  logic               rr_ptr;      // 0: q0 has priority, 1: q1 has priority
  logic [MAP_W-1:0]   map_q;
  logic [3:0]         sel_x;
  logic [3:0]         sel_y;
  logic               in_range;
  logic [IDX_W-1:0]   tile_idx;
  logic               sel_wall;

  // Next state, load handshake and query arbitration.
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    load_acc   = 1'b0;
    level_ok   = (32'(load_level) < LEVELS);
    q0_ready   = 1'b0;
    q1_ready   = 1'b0;

    case (state)
      S_IDLE:  load_ready = 1'b1;
      S_READY: load_ready = 1'b1;
      default: load_ready = 1'b0;
    endcase

    load_acc = load_valid && load_ready;

    case (state)
      S_IDLE, S_READY: if (load_acc && level_ok) state_nx = S_WAIT1;
      S_WAIT1:         state_nx = S_WAIT2;
      S_WAIT2:         state_nx = S_READY;
      default:         state_nx = S_IDLE;
    endcase

    // An accepted load (valid or not) steals the lookup slot for this cycle.
    if (state == S_READY && !load_acc) begin
      if (q0_valid && q1_valid) begin
        q0_ready = ~rr_ptr;
        q1_ready = rr_ptr;
      end else begin
        q0_ready = q0_valid;
        q1_ready = q1_valid;
      end
    end
  end

  // Single shared lookup: coordinates of whichever requester wins the slot.
  always_comb begin
    sel_x    = q1_ready ? q1_x : q0_x;
    sel_y    = q1_ready ? q1_y : q0_y;
    in_range = (32'(sel_x) < COLS) && (32'(sel_y) < ROWS);
    tile_idx = IDX_W'(sel_y) * IDX_W'(COLS) + IDX_W'(sel_x);
    sel_wall = 1'b1;  // off-map tiles read as solid
    if (in_range) sel_wall = map_q[IDX_W'(MAP_W - 1) - tile_idx];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Load bookkeeping: ROM address, map capture and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_level <= 2'd0;
      cur_level <= 2'd0;
      map_q     <= '0;
      map_valid <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      if (load_acc) begin
        if (level_ok) begin
          rom_level <= load_level;
          map_valid <= 1'b0;
        end else begin
          load_err  <= 1'b1;
        end
      end
      // map_rom has had one full cycle to register rom[rom_level].
      if (state == S_WAIT2) begin
        map_q     <= rom_map;
        cur_level <= rom_level;
        map_valid <= 1'b1;
        load_done <= 1'b1;
      end
    end
  end

  // Round-robin pointer and registered query responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r0_wall  <= 1'b0;
      r1_wall  <= 1'b0;
    end else begin
      r0_valid <= q0_ready;
      r1_valid <= q1_ready;
      if (q0_ready) begin
        rr_ptr  <= 1'b1;
        r0_wall <= sel_wall;
      end
      if (q1_ready) begin
        rr_ptr  <= 1'b0;
        r1_wall <= sel_wall;
      end
    end
  end

endmodule
`default_nettype wire
